regroup_lookup_engine: RTL
==========================

Name: regroup_lookup_engine

Overview:
- Parametrised successor of the last-node regroup lookup stage in the HCP last_node_process path.
- Buffers incoming 134-bit fragments and looks up a regroup table indexed by the TSNtag flow ID.
- Emits a 16B metadata word, then: first fragments with the TSNtag overwritten by the table DMAC; middle/last fragments with their first 16B word stripped.
- New versus the previous generation: configurable table depth, port width, FIFO depth and RAM latency; key check with hit/miss handling; per-packet output flow control; statistics counters.

Parameters:
- IDX_W, 8: table address width; table depth is 2^IDX_W.
- PORT_W, 8: outport field width. Entry width is 63+PORT_W (71 at default).
- FIFO_AW, 7: input FIFO address width; depth is 2^FIFO_AW words.
- READY_THRESH, 20: o_pkt_data_ready is high while FIFO usedw <= READY_THRESH.
- OUT_THRESH, 80: a new packet may start only while iv_fifo_usedw <= OUT_THRESH.
- RAM_LAT, 2: cycles from o_regroup_ram_rd to valid iv_regroup_ram_rdata (legal 1..3).
- MISS_DROP, 1: 1 = drop missed packet; 0 = forward missed packet to DEFAULT_PORT.
- DEFAULT_PORT, 0: outport used on a miss when MISS_DROP=0.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: asynchronous active-high reset.
- iv_pkt_data, in, 134: [133:132] 01 head / 11 body / 10 tail; [131:128] invalid-byte count; [127:0] data.
- i_pkt_data_wr, in, 1: input word valid.
- o_pkt_data_ready, out, 1: upstream may start or continue writing.
- iv_regroup_ram_rdata, in, 63+PORT_W: entry {valid[1], flowid[14], outport[PORT_W], dmac[48]}.
- o_regroup_ram_rd, out, 1: table read strobe, one cycle.
- ov_regroup_ram_raddr, out, IDX_W: table address.
- ov_pkt_data, out, 134: output word.
- o_pkt_data_wr, out, 1: output word valid.
- iv_fifo_usedw, in, 7: downstream FIFO fill level.
- ov_pkt_cnt, out, 32: packets forwarded; wraps.
- ov_miss_cnt, out, 32: lookup misses; wraps.

Behaviour:
- Reset values: all outputs 0, FIFO emptied, state IDLE. Asserting reset mid-packet discards the partial packet; no tail is emitted.
- Head-word fields:
  - TSNtag = data[127:80].
  - flowid = tag[44:31].
  - frag = tag[1:0]: 00 first, 01 middle, 10 last, 11 unfragmented (treated as first).
  - raddr = flowid[IDX_W-1:0].
- Input FIFO is show-ahead. Words written while the FIFO is full are lost; upstream must honour ready.
- IDLE: if FIFO not empty, FIFO head ctrl=01 and iv_fifo_usedw <= OUT_THRESH → pulse rd with raddr (cycle T), go to LOOKUP.
- IDLE, non-head word at FIFO head (lost sync): pop and discard it, stay in IDLE.
- LOOKUP: wait until cycle T+RAM_LAT and sample rdata. hit = valid && (entry.flowid == flowid).
  - Miss and MISS_DROP=1 → DROP; ov_miss_cnt += 1.
  - Miss and MISS_DROP=0 → META with outport = DEFAULT_PORT; ov_miss_cnt += 1.
  - Hit → META with outport = entry.outport.
- META (cycle T+RAM_LAT+1): write metadata word; no FIFO pop.
  - ctrl = 01, [131:128] = 0.
  - [127:128-PORT_W] = outport.
  - next 14 bits = flowid; next 2 bits = frag; next bit = hit; remaining bits 0.
- HEAD:
  - First/unfragmented fragment: pop the head word; emit ctrl 11, data[127:80] = DMAC on a hit (original tag kept on a forwarded miss), data[79:0] unchanged.
  - Middle/last fragment: pop and discard the head word, no write.
  - Then go to BODY.
- BODY: pop one word per cycle while the FIFO is not empty and emit it unchanged (ctrl 11 or 10). On ctrl 10, ov_pkt_cnt += 1 and go to IDLE.
  - FIFO empty mid-packet → hold without writing.
  - No downstream stall mid-packet; downstream must guarantee 128-OUT_THRESH words of slack.
- DROP: pop every word through the tail with no writes, then IDLE.
- Throughput: back-to-back packets incur RAM_LAT+1 bubble cycles between packets.

Test Plan:
- First fragment, flowid 0x005, entry {1,0x005,0x03,0x0A0B0C0D0E0F}, 4-word packet → rd/raddr 0x05 pulsed; metadata word (outport 0x03, hit=1) at T+3; head data[127:80]=0x0A0B0C0D0E0F, ctrl 11; tail intact; 5 output words total; ov_pkt_cnt=1.
- Middle fragment, 4 words, hit → metadata word plus 3 body words (ctrl 11, 11, 10); the original head word is absent.
- Flowid 0x105, entry key 0x005, MISS_DROP=1 → no output writes, ov_miss_cnt=1, FIFO empty afterwards; MISS_DROP=0 → metadata outport=DEFAULT_PORT, hit=0.
- iv_fifo_usedw=81 with a head waiting → no rd issued; drop it to 80 → rd issues the next cycle.
- Upstream burst of 30 words → ready falls once usedw reaches 21; no words lost; two back-to-back packets separated by exactly RAM_LAT+1 idle output cycles.
- i_rst pulsed during BODY → outputs 0 immediately; the next clean packet is processed correctly.

Source files
------------

// File: rtl/regroup_lookup_engine.sv
`default_nettype none
//============================================================================
// regroup_lookup_engine - HCP last-node regroup lookup: buffers fragments,
// looks up the regroup table by TSNtag flow ID, emits metadata + packet.
// Revision: 1.0
//============================================================================
module regroup_lookup_engine #(
   parameter int IDX_W        = 8,
   parameter int PORT_W       = 8,
   parameter int FIFO_AW      = 7,
   parameter int READY_THRESH = 20,
   parameter int OUT_THRESH   = 80,
   parameter int RAM_LAT      = 2,
   parameter int MISS_DROP    = 1,
   parameter int DEFAULT_PORT = 0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [133:0]        iv_pkt_data,
   input  logic                i_pkt_data_wr,
   output logic                o_pkt_data_ready,
   input  logic [62+PORT_W:0]  iv_regroup_ram_rdata,
   output logic                o_regroup_ram_rd,
   output logic [IDX_W-1:0]    ov_regroup_ram_raddr,
   output logic [133:0]        ov_pkt_data,
   output logic                o_pkt_data_wr,
   input  logic [6:0]          iv_fifo_usedw,
   output logic [31:0]         ov_pkt_cnt,
   output logic [31:0]         ov_miss_cnt
);

   localparam logic [FIFO_AW:0]  c_READY_LVL = (FIFO_AW+1)'(READY_THRESH);
   localparam logic [6:0]        c_OUT_LVL   = 7'(OUT_THRESH);
   localparam logic [1:0]        c_LAT       = 2'(RAM_LAT);
   localparam logic [PORT_W-1:0] c_DEF_PORT  = PORT_W'(DEFAULT_PORT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_HEAD   = 3'd2,
      S_BODY   = 3'd3,
      S_DROP   = 3'd4
   } state_t;

   // Input FIFO (show-ahead: head word is always visible at r_mem[r_rptr])
   logic [133:0]       r_mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] r_wptr, r_rptr;
   logic [FIFO_AW:0]   r_cnt, w_cnt_nxt;
   logic               w_full, w_empty, w_push, w_pop;
   logic [133:0]       w_head;

   assign w_full    = r_cnt[FIFO_AW];
   assign w_empty   = (r_cnt == '0);
   assign w_push    = i_pkt_data_wr & ~w_full;
   assign w_head    = r_mem[r_rptr];
   assign w_cnt_nxt = r_cnt + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= iv_pkt_data;
   end

   // Head-word and table-entry fields
   logic [1:0]        w_ctrl, w_frag;
   logic [13:0]       w_flowid;
   logic              w_first;
   logic              w_ent_valid, w_hit;
   logic [13:0]       w_ent_flow;
   logic [PORT_W-1:0] w_ent_port;
   logic [47:0]       w_ent_dmac;
   logic [133:0]      w_meta;

   assign w_ctrl      = w_head[133:132];
   assign w_flowid    = w_head[124:111];
   assign w_frag      = w_head[81:80];
   assign w_first     = (w_frag[1] == w_frag[0]);
   assign w_ent_valid = iv_regroup_ram_rdata[62+PORT_W];
   assign w_ent_flow  = iv_regroup_ram_rdata[61+PORT_W -: 14];
   assign w_ent_port  = iv_regroup_ram_rdata[47+PORT_W -: PORT_W];
   assign w_ent_dmac  = iv_regroup_ram_rdata[47:0];
   assign w_hit       = w_ent_valid && (w_ent_flow == w_flowid);

   always_comb begin
      w_meta                   = '0;
      w_meta[133:132]          = 2'b01;
      w_meta[127 -: PORT_W]    = w_hit ? w_ent_port : c_DEF_PORT;
      w_meta[127-PORT_W -: 14] = w_flowid;
      w_meta[113-PORT_W -: 2]  = w_frag;
      w_meta[111-PORT_W]       = w_hit;
   end

   state_t       r_state, w_state_nxt;
   logic [1:0]   r_lat, w_lat_nxt;
   logic         r_hit, w_hit_nxt;
   logic [47:0]  r_dmac, w_dmac_nxt;
   logic         w_rd_nxt, w_wr_nxt, w_pkt_inc, w_miss_inc;
   logic [133:0] w_data_nxt;

   // All outputs are registered, so each state's decisions appear one cycle later.
   always_comb begin
      w_state_nxt = r_state;
      w_lat_nxt   = '0;
      w_hit_nxt   = r_hit;
      w_dmac_nxt  = r_dmac;
      w_pop       = 1'b0;
      w_rd_nxt    = 1'b0;
      w_wr_nxt    = 1'b0;
      w_data_nxt  = '0;
      w_pkt_inc   = 1'b0;
      w_miss_inc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               if (w_ctrl != 2'b01) begin
                  w_pop = 1'b1;
               end else if (iv_fifo_usedw <= c_OUT_LVL) begin
                  w_rd_nxt    = 1'b1;
                  w_state_nxt = S_LOOKUP;
               end
            end
         end
         S_LOOKUP: begin
            // rdata is valid in the cycle where r_lat reaches RAM_LAT
            if (r_lat == c_LAT) begin
               w_hit_nxt  = w_hit;
               w_dmac_nxt = w_ent_dmac;
               w_miss_inc = ~w_hit;
               if (!w_hit && (MISS_DROP != 0)) begin
                  w_state_nxt = S_DROP;
               end else begin
                  w_wr_nxt    = 1'b1;
                  w_data_nxt  = w_meta;
                  w_state_nxt = S_HEAD;
               end
            end else begin
               w_lat_nxt = r_lat + 2'd1;
            end
         end
         S_HEAD: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_BODY;
               if (w_first) begin
                  w_wr_nxt   = 1'b1;
                  w_data_nxt = {2'b11, w_head[131:128],
                                (r_hit ? r_dmac : w_head[127:80]), w_head[79:0]};
               end
            end
         end
         S_BODY: begin
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_wr_nxt   = 1'b1;
               w_data_nxt = w_head;
               if (w_ctrl == 2'b10) begin
                  w_pkt_inc   = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DROP: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_ctrl == 2'b10) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state              <= S_IDLE;
         r_lat                <= '0;
         r_hit                <= 1'b0;
         r_dmac               <= '0;
         r_wptr               <= '0;
         r_rptr               <= '0;
         r_cnt                <= '0;
         o_pkt_data_ready     <= 1'b0;
         o_regroup_ram_rd     <= 1'b0;
         ov_regroup_ram_raddr <= '0;
         o_pkt_data_wr        <= 1'b0;
         ov_pkt_data          <= '0;
         ov_pkt_cnt           <= '0;
         ov_miss_cnt          <= '0;
      end else begin
         r_state          <= w_state_nxt;
         r_lat            <= w_lat_nxt;
         r_hit            <= w_hit_nxt;
         r_dmac           <= w_dmac_nxt;
         r_cnt            <= w_cnt_nxt;
         o_pkt_data_ready <= (w_cnt_nxt <= c_READY_LVL);
         o_regroup_ram_rd <= w_rd_nxt;
         o_pkt_data_wr    <= w_wr_nxt;
         ov_pkt_data      <= w_data_nxt;
         if (w_push)     r_wptr               <= r_wptr + 1'b1;
         if (w_pop)      r_rptr               <= r_rptr + 1'b1;
         if (w_rd_nxt)   ov_regroup_ram_raddr <= w_flowid[IDX_W-1:0];
         if (w_pkt_inc)  ov_pkt_cnt           <= ov_pkt_cnt + 32'd1;
         if (w_miss_inc) ov_miss_cnt          <= ov_miss_cnt + 32'd1;
      end
   end

endmodule
`default_nettype wire
